// File: rtl/wb2axi_burst_pkg.sv
// Shared encodings for the Wishbone-to-AXI burst bridge: WB cycle types,
// AXI burst/response codes, the bridge state enum and the burst-length helper.
package wb2axi_burst_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] BTE_LINEAR    = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  // Beats allowed from addr before hitting MAX_BURST, the MAX_BURST-word
  // boundary or the 4 KiB page boundary, returned as an AXI len (beats - 1).
  function automatic logic [7:0] calc_arlen(input logic [11:0] addr, input int max_burst);
    int word;
    int to_mb;
    int to_4k;
    int beats;
    word  = int'(addr[11:2]);
    to_mb = max_burst - (word % max_burst);
    to_4k = 1024 - word;
    beats = (to_mb < to_4k) ? to_mb : to_4k;
    beats = (beats < max_burst) ? beats : max_burst;
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/wb2axi_burst_if.sv
// Bundle of the Wishbone slave port and the AXI master port of the bridge.
// slave = bridge view, master = the system (WB master + AXI slave) view.
interface wb2axi_burst_if #(
  parameter int AW       = 32,
  parameter int AXI_DW   = 64,
  parameter int ID_WIDTH = 1
);
  logic [AW-1:0]       i_wb_adr;
  logic [31:0]         i_wb_dat;
  logic [3:0]          i_wb_sel;
  logic                i_wb_we;
  logic                i_wb_cyc;
  logic                i_wb_stb;
  logic [2:0]          i_wb_cti;
  logic [1:0]          i_wb_bte;
  logic [31:0]         o_wb_rdt;
  logic                o_wb_ack;
  logic                o_wb_err;

  logic [ID_WIDTH-1:0] o_awid;
  logic [AW-1:0]       o_awaddr;
  logic [7:0]          o_awlen;
  logic [2:0]          o_awsize;
  logic [1:0]          o_awburst;
  logic                o_awvalid;
  logic                i_awready;

  logic [AXI_DW-1:0]   o_wdata;
  logic [AXI_DW/8-1:0] o_wstrb;
  logic                o_wlast;
  logic                o_wvalid;
  logic                i_wready;

  logic [1:0]          i_bresp;
  logic                i_bvalid;
  logic                o_bready;

  logic [ID_WIDTH-1:0] o_arid;
  logic [AW-1:0]       o_araddr;
  logic [7:0]          o_arlen;
  logic [2:0]          o_arsize;
  logic [1:0]          o_arburst;
  logic                o_arvalid;
  logic                i_arready;

  logic [AXI_DW-1:0]   i_rdata;
  logic [1:0]          i_rresp;
  logic                i_rlast;
  logic                i_rvalid;
  logic                o_rready;

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb, i_wb_cti, i_wb_bte,
    output o_wb_rdt, o_wb_ack, o_wb_err,
    output o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
    input  i_awready,
    output o_wdata, o_wstrb, o_wlast, o_wvalid,
    input  i_wready,
    input  i_bresp, i_bvalid,
    output o_bready,
    output o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
    input  i_arready,
    input  i_rdata, i_rresp, i_rlast, i_rvalid,
    output o_rready
  );

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb, i_wb_cti, i_wb_bte,
    input  o_wb_rdt, o_wb_ack, o_wb_err,
    input  o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
    output i_awready,
    input  o_wdata, o_wstrb, o_wlast, o_wvalid,
    output i_wready,
    output i_bresp, i_bvalid,
    input  o_bready,
    input  o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
    output i_arready,
    output i_rdata, i_rresp, i_rlast, i_rvalid,
    input  o_rready
  );
endinterface

// File: rtl/wb2axi_burst_lanes.sv
// Maps the 32-bit Wishbone word onto the wide AXI data bus: write replication
// with a shifted strobe, and read selection of one 32-bit lane.
module wb2axi_burst_lanes #(
  parameter  int AXI_DW = 64,
  localparam int NLANES = AXI_DW / 32,
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic [LANE_W-1:0]   wr_lane,
  input  logic [31:0]         wb_dat,
  input  logic [3:0]          wb_sel,
  output logic [AXI_DW-1:0]   wdata,
  output logic [AXI_DW/8-1:0] wstrb,
  input  logic [LANE_W-1:0]   rd_lane,
  input  logic [AXI_DW-1:0]   rdata,
  output logic [31:0]         rdt
);

  assign wdata = {NLANES{wb_dat}};
  assign rdt   = rdata[{rd_lane, 5'b00000} +: 32];

  always_comb begin
    wstrb = '0;
    wstrb[{wr_lane, 2'b00} +: 4] = wb_sel;
  end

endmodule

// File: rtl/wb2axi_burst.sv
// Wishbone B4 slave to AXI4 master bridge: single-beat writes, classic and
// incrementing reads mapped to AXI read bursts, one AXI transaction at a time.
module wb2axi_burst
  import wb2axi_burst_pkg::*;
#(
  parameter int AW        = 32,
  parameter int AXI_DW    = 64,
  parameter int MAX_BURST = 8,
  parameter int ID_WIDTH  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  wb2axi_burst_if.slave     bus
);

  localparam int NLANES = AXI_DW / 32;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int SW     = AXI_DW / 8;

  state_e            state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q, bready_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [AXI_DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [AW-3:0]     exp_q, exp_d;
  logic [31:0]       rdt_q, rdt_d;

  logic              wb_req;
  logic              adr_match;
  logic              rready;
  logic              r_hs;
  logic              rd_abort;
  logic [LANE_W-1:0] wr_lane;
  logic [LANE_W-1:0] rd_lane;
  logic [AXI_DW-1:0] lane_wdata;
  logic [SW-1:0]     lane_wstrb;
  logic [31:0]       lane_rdt;
  logic              unused;

  assign unused = ^{bus.i_wb_adr[1:0], bus.i_bresp[0], bus.i_rresp[0]};

  generate
    if (NLANES > 1) begin : g_lanes
      assign wr_lane = bus.i_wb_adr[LANE_W+1:2];
      assign rd_lane = exp_q[LANE_W-1:0];
    end else begin : g_one_lane
      assign wr_lane = '0;
      assign rd_lane = '0;
    end
  endgenerate

  wb2axi_burst_lanes #(.AXI_DW(AXI_DW)) u_lanes (
    .wr_lane (wr_lane),
    .wb_dat  (bus.i_wb_dat),
    .wb_sel  (bus.i_wb_sel),
    .wdata   (lane_wdata),
    .wstrb   (lane_wstrb),
    .rd_lane (rd_lane),
    .rdata   (bus.i_rdata),
    .rdt     (lane_rdt)
  );

  // rready stays combinational so a beat is only taken while the WB master
  // is actually asking for the word the burst is about to deliver.
  assign wb_req    = bus.i_wb_cyc & bus.i_wb_stb;
  assign adr_match = (bus.i_wb_adr[AW-1:2] == exp_q);
  assign rready    = (state_q == ST_DRAIN) |
                     ((state_q == ST_RDATA) & wb_req & ~bus.i_wb_we & ~ack_q & ~err_q & adr_match);
  assign r_hs      = bus.i_rvalid & rready;
  assign rd_abort  = ~bus.i_wb_cyc |
                     (~ack_q & ~err_q & bus.i_wb_stb & (bus.i_wb_we | ~adr_match));

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    arlen_d   = arlen_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    exp_d     = exp_q;
    rdt_d     = rdt_q;

    unique case (state_q)
      // A pending ack/err blocks new requests so the master can drop stb.
      ST_IDLE: begin
        if (wb_req & ~ack_q & ~err_q) begin
          addr_d = {bus.i_wb_adr[AW-1:2], 2'b00};
          if (bus.i_wb_we) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = lane_wdata;
            wstrb_d   = lane_wstrb;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
            exp_d     = bus.i_wb_adr[AW-1:2];
            arlen_d   = (bus.i_wb_cti == CTI_INCR && bus.i_wb_bte == BTE_LINEAR)
                        ? calc_arlen(bus.i_wb_adr[11:0], MAX_BURST) : 8'd0;
          end
        end
      end
      ST_WRITE: begin
        if (bus.i_awready) awvalid_d = 1'b0;
        if (bus.i_wready)  wvalid_d  = 1'b0;
        if (~awvalid_d & ~wvalid_d) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bus.i_bvalid) begin
          bready_d = 1'b0;
          ack_d    = ~bus.i_bresp[1];
          err_d    = bus.i_bresp[1];
          state_d  = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (bus.i_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          ack_d = ~bus.i_rresp[1];
          err_d = bus.i_rresp[1];
          rdt_d = lane_rdt;
          exp_d = exp_q + 1'b1;
          if (bus.i_rlast) state_d = ST_IDLE;
        end else if (rd_abort) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.i_rvalid & bus.i_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      arlen_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      exp_q     <= '0;
      rdt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      arlen_q   <= arlen_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      exp_q     <= exp_d;
      rdt_q     <= rdt_d;
    end
  end

  assign bus.o_wb_rdt  = rdt_q;
  assign bus.o_wb_ack  = ack_q;
  assign bus.o_wb_err  = err_q;

  assign bus.o_awid    = '0;
  assign bus.o_awaddr  = addr_q;
  assign bus.o_awlen   = 8'd0;
  assign bus.o_awsize  = AXI_SIZE_WORD;
  assign bus.o_awburst = BURST_INCR;
  assign bus.o_awvalid = awvalid_q;

  assign bus.o_wdata   = wdata_q;
  assign bus.o_wstrb   = wstrb_q;
  assign bus.o_wlast   = 1'b1;
  assign bus.o_wvalid  = wvalid_q;
  assign bus.o_bready  = bready_q;

  assign bus.o_arid    = '0;
  assign bus.o_araddr  = addr_q;
  assign bus.o_arlen   = arlen_q;
  assign bus.o_arsize  = AXI_SIZE_WORD;
  assign bus.o_arburst = BURST_INCR;
  assign bus.o_arvalid = arvalid_q;
  assign bus.o_rready  = rready;

endmodule

// File: tb/tb_wb2axi_burst.sv
// Directed bench for the WB-to-AXI bridge: WB master and AXI slave are driven
// from tasks; read data comes from an address-derived pattern.
module tb_wb2axi_burst;

  localparam int AW        = 32;
  localparam int AXI_DW    = 64;
  localparam int MAX_BURST = 8;
  localparam int ID_WIDTH  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   aw_hs = 0;
  int   w_hs  = 0;
  int   ar_hs = 0;

  always #5 clk = ~clk;

  wb2axi_burst_if #(.AW(AW), .AXI_DW(AXI_DW), .ID_WIDTH(ID_WIDTH)) bus ();

  wb2axi_burst #(
    .AW(AW), .AXI_DW(AXI_DW), .MAX_BURST(MAX_BURST), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Handshake counters sampled mid-cycle, when everything is stable.
  always @(negedge clk) begin
    if (bus.o_awvalid && bus.i_awready) aw_hs++;
    if (bus.o_wvalid && bus.i_wready)   w_hs++;
    if (bus.o_arvalid && bus.i_arready) ar_hs++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [63:0] memBeat(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {memWord(b + 32'd4), memWord(b)};
  endfunction

  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [2:0] cti);
    bus.i_wb_cyc = cyc;
    bus.i_wb_stb = stb;
    bus.i_wb_we  = we;
    bus.i_wb_adr = adr;
    bus.i_wb_dat = dat;
    bus.i_wb_sel = sel;
    bus.i_wb_cti = cti;
    bus.i_wb_bte = 2'b00;
  endtask

  task automatic doWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input int awDly, input int wDly, input logic [1:0] bresp,
                         input logic [7:0] expStrb);
    int awBase;
    int wBase;
    int n;
    awBase = aw_hs;
    wBase  = w_hs;
    applyStimulus(1'b1, 1'b1, 1'b1, adr, dat, sel, 3'b000);
    tick();
    checkOutput("awvalid", bus.o_awvalid, 1);
    checkOutput("wvalid", bus.o_wvalid, 1);
    checkOutput("awaddr", bus.o_awaddr, {adr[31:2], 2'b00});
    checkOutput("awlen", bus.o_awlen, 0);
    checkOutput("wstrb", bus.o_wstrb, expStrb);
    checkOutput("wdata", bus.o_wdata, {dat, dat});
    n = 0;
    while (!bus.o_bready && n < 20) begin
      bus.i_awready = (n >= awDly);
      bus.i_wready  = (n >= wDly);
      tick();
      n++;
    end
    bus.i_awready = 1'b0;
    bus.i_wready  = 1'b0;
    checkOutput("bready", bus.o_bready, 1);
    checkOutput("aw_count", 64'(aw_hs - awBase), 1);
    checkOutput("w_count", 64'(w_hs - wBase), 1);
    bus.i_bresp  = bresp;
    bus.i_bvalid = 1'b1;
    tick();
    bus.i_bvalid = 1'b0;
    checkOutput("wr_ack", bus.o_wb_ack, !bresp[1]);
    checkOutput("wr_err", bus.o_wb_err, bresp[1]);
    checkOutput("bready_clr", bus.o_bready, 0);
    // stb deliberately held through the ack cycle
    tick();
    checkOutput("no_reissue", bus.o_awvalid, 0);
    checkOutput("pulse_end", bus.o_wb_ack | bus.o_wb_err, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();
  endtask

  task automatic doRead(input logic [31:0] adr, input int nWb, input bit incr, input bit early,
                        input logic [7:0] expLen, input int errBeat,
                        input int expAcks, input int expErrs);
    int beat;
    int done;
    int acks;
    int errs;
    int n;
    int arBase;
    logic [31:0] cur;
    logic [31:0] araddr;
    logic [2:0]  cti;
    arBase = ar_hs;
    araddr = {adr[31:2], 2'b00};
    applyStimulus(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'h0, incr ? 3'b010 : 3'b000);
    tick();
    n = 0;
    while (!bus.o_arvalid && n < 10) begin
      tick();
      n++;
    end
    checkOutput("arvalid", bus.o_arvalid, 1);
    checkOutput("araddr", bus.o_araddr, araddr);
    checkOutput("arlen", bus.o_arlen, expLen);
    bus.i_arready = 1'b1;
    tick();
    bus.i_arready = 1'b0;
    checkOutput("arvalid_clr", bus.o_arvalid, 0);
    beat = 0; done = 0; acks = 0; errs = 0; n = 0;
    cur  = araddr;
    while (n < 200) begin
      if (bus.o_wb_ack || bus.o_wb_err) begin
        if (bus.o_wb_ack) begin
          acks++;
          checkOutput("rdt", bus.o_wb_rdt, memWord(cur));
        end else begin
          errs++;
        end
        done++;
        cur = cur + 32'd4;
      end
      if (done >= nWb && beat > int'(expLen)) break;
      if (done >= nWb) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
      end else begin
        cti = !incr ? 3'b000 : ((done == nWb - 1 && !early) ? 3'b111 : 3'b010);
        applyStimulus(1'b1, 1'b1, 1'b0, cur, 32'h0, 4'h0, cti);
      end
      if (beat <= int'(expLen)) begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = memBeat(araddr + 32'(4 * beat));
        bus.i_rlast  = (beat == int'(expLen));
        bus.i_rresp  = (beat == errBeat) ? 2'b11 : 2'b00;
      end else begin
        bus.i_rvalid = 1'b0;
        bus.i_rlast  = 1'b0;
      end
      #1;
      if (bus.i_rvalid && bus.o_rready) beat++;
      tick();
      n++;
    end
    bus.i_rvalid = 1'b0;
    bus.i_rlast  = 1'b0;
    bus.i_rresp  = 2'b00;
    checkOutput("rd_acks", 64'(acks), 64'(expAcks));
    checkOutput("rd_errs", 64'(errs), 64'(expErrs));
    checkOutput("rd_beats", 64'(beat), 64'(int'(expLen) + 1));
    checkOutput("ar_count", 64'(ar_hs - arBase), 1);
    checkOutput("rready_idle", bus.o_rready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();
    checkOutput("no_new_ar", bus.o_arvalid, 0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    bus.i_awready = 1'b0;
    bus.i_wready  = 1'b0;
    bus.i_bresp   = 2'b00;
    bus.i_bvalid  = 1'b0;
    bus.i_arready = 1'b0;
    bus.i_rdata   = '0;
    bus.i_rresp   = 2'b00;
    bus.i_rlast   = 1'b0;
    bus.i_rvalid  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_awvalid", bus.o_awvalid, 0);
    checkOutput("rst_wvalid", bus.o_wvalid, 0);
    checkOutput("rst_arvalid", bus.o_arvalid, 0);
    checkOutput("rst_bready", bus.o_bready, 0);
    checkOutput("rst_rready", bus.o_rready, 0);
    checkOutput("rst_ack_err", {bus.o_wb_ack, bus.o_wb_err}, 0);
    checkOutput("rst_rdt", bus.o_wb_rdt, 0);
    rst = 1'b0;
    tick();

    doWrite(32'h104, 32'hCAFE_BABE, 4'b0011, 0, 0, 2'b00, 8'h30);
    doWrite(32'h200, 32'h1234_5678, 4'b1111, 0, 3, 2'b00, 8'h0F);
    doWrite(32'h30C, 32'h0BAD_F00D, 4'b1000, 3, 0, 2'b00, 8'h80);
    doWrite(32'h400, 32'h55AA_55AA, 4'b0100, 1, 1, 2'b10, 8'h04);

    doRead(32'h1000, 8, 1'b1, 1'b0, 8'd7, -1, 8, 0);
    doRead(32'h0FF8, 2, 1'b1, 1'b0, 8'd1, -1, 2, 0);
    doRead(32'h1010, 4, 1'b1, 1'b0, 8'd3, -1, 4, 0);
    doRead(32'h3000, 1, 1'b1, 1'b1, 8'd7, -1, 1, 0);
    doRead(32'h0504, 1, 1'b0, 1'b0, 8'd0, -1, 1, 0);
    doRead(32'h0208, 1, 1'b0, 1'b0, 8'd0, 0, 0, 1);

    // Reset in the middle of a read burst abandons it outright.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 3'b010);
    tick();
    checkOutput("rst_test_arlen", bus.o_arlen, 7);
    bus.i_arready = 1'b1;
    tick();
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b1;
    bus.i_rdata   = memBeat(32'h2000);
    bus.i_rlast   = 1'b0;
    tick();
    checkOutput("rst_test_ack", bus.o_wb_ack, 1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_awvalid", bus.o_awvalid, 0);
    checkOutput("midrst_wvalid", bus.o_wvalid, 0);
    checkOutput("midrst_arvalid", bus.o_arvalid, 0);
    checkOutput("midrst_bready", bus.o_bready, 0);
    checkOutput("midrst_rready", bus.o_rready, 0);
    checkOutput("midrst_ack_err", {bus.o_wb_ack, bus.o_wb_err}, 0);
    checkOutput("midrst_rdt", bus.o_wb_rdt, 0);
    rst = 1'b0;
    bus.i_rvalid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();
    doRead(32'h030C, 1, 1'b0, 1'b0, 8'd0, -1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb2axi_burst.md
WB2AXI_BURST -- requirements
Module: wb2axi_burst

Interface
REQ-001 Parameter AW, default 32: address width on both Wishbone and AXI sides.
REQ-002 Parameter AXI_DW, default 64: AXI data width; power of two, 32..256.
REQ-003 Parameter MAX_BURST, default 8: maximum AXI read burst beats; power of two, 1..256.
REQ-004 Parameter ID_WIDTH, default 1: AXI ID width; o_awid and o_arid are tied to 0.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 i_clk  in  1  clock; all logic on the rising edge.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_wb_adr  in  AW  Wishbone byte address; bits [1:0] ignored.
REQ-009 i_wb_dat  in  32  Wishbone write data.
REQ-010 i_wb_sel  in  4  Wishbone byte selects.
REQ-011 i_wb_we, i_wb_cyc, i_wb_stb  in  1 each  Wishbone write enable, cycle and strobe.
REQ-012 i_wb_cti  in  3  cycle type; 3'b000 classic, 3'b010 incrementing, 3'b111 end-of-burst.
REQ-013 i_wb_bte  in  2  burst type extension; only 2'b00 (linear) is supported, other values are treated as classic.
REQ-014 o_wb_rdt  out  32  read data; o_wb_ack, o_wb_err  out  1 each, single-cycle pulses.
REQ-015 AW channel  out: o_awid[ID_WIDTH], o_awaddr[AW], o_awlen[8], o_awsize[3], o_awburst[2], o_awvalid; in: i_awready.
REQ-016 W channel  out: o_wdata[AXI_DW], o_wstrb[AXI_DW/8], o_wlast, o_wvalid; in: i_wready.
REQ-017 B channel  in: i_bresp[2], i_bvalid; out: o_bready.
REQ-018 AR channel  out: o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid; in: i_arready.
REQ-019 R channel  in: i_rdata[AXI_DW], i_rresp[2], i_rlast, i_rvalid; out: o_rready.

Function
REQ-020 States SHALL be IDLE, WRITE, WRESP, RADDR, RDATA, DRAIN.
REQ-021 IDLE with cyc&stb&we -> WRITE; cyc&stb&~we -> RADDR.
REQ-022 Writes SHALL always be single beats (awlen=0, awsize=2, burst INCR, wlast=1); o_awvalid and o_wvalid assert together; each drops independently on its own ready, in either order or in the same cycle.
REQ-023 Write lane steering SHALL place i_wb_dat on every 32-bit lane; o_wstrb = i_wb_sel shifted to lane adr[log2(AXI_DW/8)-1:2], all other strobes 0.
REQ-024 WRESP: o_bready=1; on i_bvalid, o_wb_ack=1 if bresp[1]=0, else o_wb_err=1; next state IDLE.
REQ-025 RADDR: o_araddr = adr with bits [1:0] cleared; arsize=2; for classic cti, arlen=0; for cti=3'b010, arlen = min(MAX_BURST, beats to the next MAX_BURST*4-byte boundary, beats to the next 4 KiB boundary) - 1.
REQ-026 RDATA: o_rready = cyc & stb & ~we & ~o_wb_ack & ~o_wb_err & (adr == expected address); expected address starts at araddr and advances by 4 per beat.
REQ-027 Read ack/err SHALL be registered one cycle after i_rvalid&o_rready; o_wb_rdt = the selected 32-bit lane of i_rdata, captured the same cycle; err when rresp[1]=1.
REQ-028 After i_rlast is accepted, the next state SHALL be IDLE.
REQ-029 In RDATA, if cyc drops, we rises, or adr mismatches before rlast, the next state SHALL be DRAIN; DRAIN holds o_rready=1, discards beats and generates no ack, and moves to IDLE on rlast.
REQ-030 An ack or err SHALL be followed by at least one cycle with no new AXI request issued, so that WB stb-deassertion latency is honoured.
REQ-031 The block SHALL have at most one outstanding AXI transaction.

Reset
REQ-032 On i_rst the state SHALL be IDLE; o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wb_ack and o_wb_err SHALL be 0; o_wb_rdt SHALL be 0.
REQ-033 Reset mid-transaction SHALL abandon it without draining; the system resets the interconnect in the same cycle.

Structure
REQ-034 The shared package SHALL hold the CTI codes, the AXI burst/resp encodings and the state enum.
REQ-035 Lane steering (write replication/strobe shift, read lane select) SHALL live in the sub-module wb2axi_burst_lanes.

Verification
REQ-036 Classic write, adr=0x104, sel=4'b0011, AXI_DW=64 -> wstrb=8'h30, wdata lanes both 32'h data; ack one cycle after bvalid.
REQ-037 awready 3 cycles before wready, then reverse -> exactly one AW and one W handshake per access.
REQ-038 Incrementing read at 0x1000, MAX_BURST=8, stb held 8 beats ending cti=111 -> arlen=7, 8 acks, data in address order.
REQ-039 Incrementing read at 0xFF8 -> arlen=1 (4 KiB boundary); an early cyc drop after beat 1 of an arlen=7 burst -> DRAIN consumes 7 beats, no extra acks, next access proceeds.
REQ-040 bresp=2'b10 and rresp=2'b11 -> o_wb_err pulse, no ack; i_rst asserted in RDATA -> all valids/readies 0 on the next cycle.
